// File: rtl/aes_pkg.sv
// Shared AES definitions: field polynomial, MixColumns FSM states and GF(2^8) helpers.
// Reused by the forward/inverse MixColumns engines and the key schedule.
package aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;

  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned COL_W    = 32;
  localparam int unsigned STATE_W  = 128;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mc_state_e;

  // Multiply by x modulo the AES polynomial; a[7] is the byte MSB.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] a);
    return xtime(a) ^ a;
  endfunction

endpackage

// File: rtl/mix_col32.sv
// Combinational MixColumns of one 32-bit column; row 0 byte sits in bits [31:24].
module mix_col32
  import aes_pkg::*;
(
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] r0, r1, r2, r3;

  assign a0 = col_i[31:24];
  assign a1 = col_i[23:16];
  assign a2 = col_i[15:8];
  assign a3 = col_i[7:0];

  always_comb begin
    r0 = xtime(a0) ^ mul3(a1) ^ a2 ^ a3;
    r1 = a0 ^ xtime(a1) ^ mul3(a2) ^ a3;
    r2 = a0 ^ a1 ^ xtime(a2) ^ mul3(a3);
    r3 = mul3(a0) ^ a1 ^ a2 ^ xtime(a3);
  end

  assign col_o = {r0, r1, r2, r3};

endmodule

// File: rtl/mix_columns_fwd.sv
// Forward AES MixColumns engine: captures a 128-bit state, mixes one column per cycle,
// and presents the result on a valid/ready output until accepted.
module mix_columns_fwd
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [0:127] state_i,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [0:127] state_o,
  output logic         out_valid,
  input  logic         out_ready
);

  mc_state_e    state_q, state_d;
  logic [1:0]   col_q, col_d;
  logic [0:127] work_q, work_d;

  logic [31:0]  col_sel;
  logic [31:0]  col_mixed;

  // Single shared column mixer; col_q selects which column it sees.
  always_comb begin
    col_sel = 32'h0;
    unique case (col_q)
      2'd0: col_sel = work_q[0:31];
      2'd1: col_sel = work_q[32:63];
      2'd2: col_sel = work_q[64:95];
      2'd3: col_sel = work_q[96:127];
      default: col_sel = 32'h0;
    endcase
  end

  mix_col32 u_mix_col32 (
    .col_i (col_sel),
    .col_o (col_mixed)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    work_d  = work_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = state_i;
          col_d   = 2'd0;
          state_d = BUSY;
        end
      end

      BUSY: begin
        unique case (col_q)
          2'd0: work_d[0:31]   = col_mixed;
          2'd1: work_d[32:63]  = col_mixed;
          2'd2: work_d[64:95]  = col_mixed;
          2'd3: work_d[96:127] = col_mixed;
          default: work_d = work_q;
        endcase
        // Natural 2-bit wrap leaves col at 0 when entering DONE.
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) begin
          state_d = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      work_q  <= work_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign state_o   = work_q;

  // Held output must not change while the consumer stalls.
  a_hold_under_backpressure : assert property (
    @(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(state_o))
  );

  a_one_hot_handshake : assert property (
    @(posedge clk) disable iff (!rst_n)
    !(in_ready && out_valid)
  );

endmodule

// File: tb/tb_mix_columns_fwd.sv
// Self-checking bench for mix_columns_fwd against a generic GF(2^8) matrix model.
module tb_mix_columns_fwd;

  logic         clk;
  logic         rst_n;
  logic [0:127] state_i;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] state_o;
  logic         out_valid;
  logic         out_ready;

  int total = 0;
  int bad   = 0;

  mix_columns_fwd dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .state_i   (state_i),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_o   (state_o),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generic shift-and-add multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in;
    b = b_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      if (a[7]) a = (a << 1) ^ 8'h1B;
      else      a = a << 1;
      b = b >> 1;
    end
    return p;
  endfunction

  // Circulant matrix product: coefficient for output row r, input row i is {2,3,1,1}[(i-r) mod 4].
  function automatic logic [0:127] model(input logic [0:127] s);
    logic [0:127] r;
    logic [7:0]   coef [4];
    logic [7:0]   acc, b;
    coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int i = 0; i < 4; i++) begin
          b   = s[8*(4*c+i) +: 8];
          acc = acc ^ gmul(coef[(i - row + 4) % 4], b);
        end
        r[8*(4*c+row) +: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [0:127] rand_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drives one state through both handshakes; no checking here, callers compare.
  task automatic run_one(input logic [0:127] s, output logic [0:127] r, output int lat,
                         output bit ok);
    int n;
    ok       = 1'b1;
    r        = '0;
    lat      = 0;
    state_i  = s;
    in_valid = 1'b1;
    n        = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      ok       = 1'b0;
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      ok = 1'b0;
      return;
    end
    r         = state_o;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid);
    end
    total++;
    if (state_o !== 128'h0) begin
      bad++; $display("FAIL reset_state_o got=%h want=0", state_o);
    end
  endtask

  task automatic test_fips();
    logic [0:127] s, r, exp;
    int lat;
    bit ok;
    s   = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    exp = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    run_one(s, r, lat, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL fips_timeout got=timeout want=handshake");
    end
    total++;
    if (r !== exp) begin
      bad++; $display("FAIL fips_result got=%h want=%h", r, exp);
    end
    total++;
    if (r !== model(s)) begin
      bad++; $display("FAIL fips_model got=%h want=%h", r, model(s));
    end
    total++;
    if (lat !== 4) begin
      bad++; $display("FAIL fips_latency got=%0d want=4", lat);
    end
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL fips_post_handshake got=ov%b ir%b want=ov0 ir1", out_valid, in_ready);
    end
  endtask

  task automatic test_second();
    logic [0:127] s, r, exp;
    int lat;
    bit ok;
    s   = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    exp = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
    run_one(s, r, lat, ok);
    total++;
    if (!ok || r !== exp) begin
      bad++; $display("FAIL second_result got=%h ok=%0d want=%h", r, ok, exp);
    end
  endtask

  task automatic test_backpressure();
    logic [0:127] s, exp, held;
    int n;
    s   = rand_state();
    exp = model(s);
    state_i  = s;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!out_valid) begin
      bad++; $display("FAIL bp_timeout got=timeout want=out_valid");
    end
    held     = state_o;
    total++;
    if (held !== exp) begin
      bad++; $display("FAIL bp_result got=%h want=%h", held, exp);
    end
    // A competing input must be ignored while the result waits.
    state_i  = rand_state();
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (state_o !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold cyc=%0d got=%h ov%b ir%b want=%h ov1 ir0",
                 i, state_o, out_valid, in_ready, exp);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || state_o !== exp) begin
      bad++;
      $display("FAIL bp_release got=%h ov%b ir%b want=%h ov0 ir1",
               state_o, out_valid, in_ready, exp);
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [0:127] s, r;
    int lat;
    bit ok;
    state_i  = rand_state();
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || state_o !== 128'h0) begin
      bad++; $display("FAIL rst_busy_async got=%h ov%b want=0 ov0", state_o, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL rst_busy_in_ready got=%b want=1", in_ready);
    end
    @(negedge clk);
    s = rand_state();
    run_one(s, r, lat, ok);
    total++;
    if (!ok || r !== model(s) || lat !== 4) begin
      bad++;
      $display("FAIL rst_busy_next got=%h lat=%0d ok=%0d want=%h lat=4", r, lat, ok, model(s));
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 1000;
    logic [0:127] q [$];
    logic [0:127] exp;
    int sent, got, cyc, last_acc;
    bit acc;
    sent      = 0;
    got       = 0;
    cyc       = 0;
    last_acc  = -1;
    out_ready = 1'b1;
    state_i   = rand_state();
    in_valid  = 1'b1;
    while (got < N && cyc < 8000) begin
      if (out_valid) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL b2b_unexpected got=%h want=none", state_o);
        end else begin
          exp = q.pop_front();
          if (state_o !== exp) begin
            bad++; $display("FAIL b2b_result idx=%0d got=%h want=%h", got, state_o, exp);
          end
        end
        got++;
      end
      acc = in_ready && in_valid;
      if (acc) begin
        q.push_back(model(state_i));
        if (last_acc >= 0) begin
          total++;
          if (cyc - last_acc !== 6) begin
            bad++; $display("FAIL b2b_interval got=%0d want=6", cyc - last_acc);
          end
        end
        last_acc = cyc;
      end
      @(negedge clk);
      cyc++;
      if (acc) begin
        sent++;
        if (sent < N) state_i = rand_state();
        else          in_valid = 1'b0;
      end
    end
    total++;
    if (got !== N) begin
      bad++; $display("FAIL b2b_count got=%0d want=%0d", got, N);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_xtime_boundary();
    logic [0:127] s, r;
    int lat;
    bit ok;
    s = {16{8'h80}};
    run_one(s, r, lat, ok);
    total++;
    if (!ok || r !== {16{8'h80}}) begin
      bad++; $display("FAIL xtime_const got=%h want=%h", r, {16{8'h80}});
    end
    total++;
    if (r !== model(s)) begin
      bad++; $display("FAIL xtime_model got=%h want=%h", r, model(s));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    state_i   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    test_reset();
    @(negedge clk);
    test_fips();
    test_second();
    test_backpressure();
    test_reset_mid_busy();
    test_back_to_back();
    test_xtime_boundary();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mix_columns_fwd.md
# mix_columns_fwd

Forward AES MixColumns engine for the encryption datapath, the counterpart of the inverse MixColumns path built from the 0x09/0x0B/0x0D/0x0E multipliers. It accepts one 128-bit state over a valid/ready handshake and processes one 32-bit column per cycle using GF(2^8) xtime. It returns the mixed state over a second valid/ready handshake. It sits between ShiftRows and AddRoundKey in each encryption round except the last.

## Interface
- No parameters; widths are fixed by AES-128.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- state_i  in  [0:127]  input state, column-major. Byte k is bits [8k:8k+7], and bit 8k is the byte MSB. Column c holds bytes 4c..4c+3, row 0 first.
- in_valid  in  1  state_i is valid.
- in_ready  out  1  block can accept a state.
- state_o  out  [0:127]  mixed state, same byte layout as state_i.
- out_valid  out  1  state_o is valid.
- out_ready  in  1  downstream accepts state_o.

## Operation
- Arithmetic:
  - xtime(a) = (a << 1) ^ (a[0] ? 8'h1B : 8'h00), where a[0] is the MSB.
  - mul3(a) = xtime(a) ^ a.
- Column equations for input a0..a3 and output r0..r3:
  - r0 = 2a0^3a1^a2^a3
  - r1 = a0^2a1^3a2^a3
  - r2 = a0^a1^2a2^3a3
  - r3 = 3a0^a1^a2^2a3
- FSM states:
  - IDLE:
    - in_ready=1.
    - On in_valid, capture state_i into the working register, set col=0, go to BUSY.
  - BUSY:
    - in_ready=0.
    - Each cycle, replace column col of the working register with its mixed value, then increment col.
    - After col=3 is written, go to DONE.
  - DONE:
    - out_valid=1.
    - state_o holds the result, stable until accepted.
    - On out_ready, go to IDLE.
- col is a 2-bit counter. It wraps 3→0 only on the BUSY→DONE transition and is cleared on capture.
- in_valid while not in IDLE is ignored; upstream must hold it until in_ready.
- Backpressure: while DONE and out_ready=0, hold state_o and out_valid indefinitely. No new input is accepted.
- Reset, including mid-BUSY or mid-DONE:
  - FSM to IDLE, col=0, working register=0.
  - Outputs: state_o=0, out_valid=0. in_ready=1 as soon as reset releases.
  - A partially mixed state is discarded and never emitted.

## Timing
- Acceptance edge E0: in_valid & in_ready. Column c is written on edge E(c+1).
- out_valid rises after E4, so latency is 4 cycles from acceptance edge to out_valid.
- Output handshake edge (out_valid & out_ready) returns to IDLE. in_ready=1 the following cycle.
- Minimum initiation interval: 6 cycles per state (accept, 4 mix, 1 handshake, with out_ready tied high).
- state_o is driven directly from the working register, with no combinational path from inputs to outputs.
- in_ready and out_valid are decoded from the registered FSM state only.

## Structure
- Shared package aes_pkg:
  - constant AES_POLY = 8'h1B.
  - FSM state type {IDLE, BUSY, DONE}.
  - functions xtime and mul3, also for reuse by the key schedule and inverse multipliers.
- Sub-module mix_col32:
  - Purely combinational.
  - 32-bit column in, 32-bit mixed column out.
  - One instance, fed by a column mux on col.
  - The write-back demux lives in mix_columns_fwd.
- No clocked multiplier stages.

## Test plan
- FIPS-197 column vectors, sent as a full state:
  - Input columns db135345 | f20a225c | 01010101 | c6c6c6c6.
  - Expect state_o = 8e4da1bc | 9fdc589d | 01010101 | c6c6c6c6.
  - out_valid must rise exactly 4 cycles after the accept edge.
- Second state:
  - Input columns d4d4d4d5 | 2d26314c | 00000000 | ffffffff.
  - Expect d5d5d7d6 | 4d7ebdf8 | 00000000 | ffffffff.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid.
  - Check state_o is stable, in_ready=0, and a new in_valid is ignored.
  - Release out_ready; check a one-cycle handshake, then in_ready=1.
- Reset mid-BUSY:
  - Assert rst_n=0 two cycles after acceptance.
  - Check out_valid=0 and state_o=0 immediately, because reset is asynchronous.
  - After release, check in_ready=1 and that the next state is processed correctly.
- Back-to-back with out_ready=1 and in_valid held high:
  - Accept a new state every 6 cycles.
  - Check results are in order and match the reference model over 1000 random states.
- xtime boundary:
  - Input with all bytes 0x80.
  - Each column yields 80808080, since 2·80 = 1B, 3·80 = 9B, and 1B^9B^80^80 = 80.
  - Compare against the model.
